// File: rtl/fp_mul_scheduler.sv
// Round-robin scheduler sharing one start/busy/done FP multiplier among NUM_REQ requesters.
// Optional watchdog: define FP_MUL_SCHED_TIMEOUT_EN to return a canonical NaN on a stuck multiplier.
module fp_mul_scheduler #(
    parameter int unsigned FLEN           = 32,
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned TAG_W          = 5,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*FLEN-1:0]  req_operand_a,
    input  logic [NUM_REQ*FLEN-1:0]  req_operand_b,
    input  logic [NUM_REQ*3-1:0]     req_rm,
    input  logic [NUM_REQ*TAG_W-1:0] req_tag,
    output logic [NUM_REQ-1:0]       resp_valid,
    input  logic [NUM_REQ-1:0]       resp_ready,
    output logic [FLEN-1:0]          resp_result,
    output logic [4:0]               resp_flags,
    output logic [TAG_W-1:0]         resp_tag,
    output logic                     mul_start,
    output logic [2:0]               mul_rounding_mode,
    output logic [FLEN-1:0]          mul_operand_a,
    output logic [FLEN-1:0]          mul_operand_b,
    input  logic                     mul_busy,
    input  logic                     mul_done,
    input  logic [FLEN-1:0]          mul_result,
    input  logic [3:0]               mul_flags
);

    localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e           state_q;
    logic [PW-1:0]    rr_ptr_q;
    logic [PW-1:0]    owner_q;
    logic [TAG_W-1:0] tag_q;

    logic [PW-1:0]    grant_idx;
    logic             grant_found;
    logic             can_grant;
    int unsigned      idx;

`ifdef FP_MUL_SCHED_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FLEN-1:0] CanonNan = (FLEN == 64) ? FLEN'(64'h7FF8_0000_0000_0000)
                                                        : FLEN'(32'h7FC0_0000);
    logic [CntW-1:0] timeout_cnt_q;
`endif

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!grant_found && req_valid[idx[PW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = idx[PW-1:0];
            end
        end
    end

    // A multiplier still busy or finishing from before reset must drain before any grant.
    assign can_grant = (state_q == StIdle) && !reset && !mul_busy && !mul_done && grant_found;

    always_comb begin
        req_ready = '0;
        if (can_grant) req_ready[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= StIdle;
            rr_ptr_q          <= '0;
            owner_q           <= '0;
            tag_q             <= '0;
            mul_start         <= 1'b0;
            mul_rounding_mode <= '0;
            mul_operand_a     <= '0;
            mul_operand_b     <= '0;
            resp_valid        <= '0;
            resp_result       <= '0;
            resp_flags        <= '0;
            resp_tag          <= '0;
`ifdef FP_MUL_SCHED_TIMEOUT_EN
            timeout_cnt_q     <= '0;
`endif
        end else begin
            mul_start <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (can_grant) begin
                        mul_operand_a     <= req_operand_a[grant_idx*FLEN +: FLEN];
                        mul_operand_b     <= req_operand_b[grant_idx*FLEN +: FLEN];
                        mul_rounding_mode <= req_rm[grant_idx*3 +: 3];
                        tag_q             <= req_tag[grant_idx*TAG_W +: TAG_W];
                        owner_q           <= grant_idx;
                        rr_ptr_q          <= (grant_idx == PW'(NUM_REQ - 1)) ? '0
                                                                             : grant_idx + 1'b1;
                        mul_start         <= 1'b1;
                        state_q           <= StIssue;
                    end
                end
                StIssue: begin
`ifdef FP_MUL_SCHED_TIMEOUT_EN
                    timeout_cnt_q <= '0;
`endif
                    state_q <= StWait;
                end
                StWait: begin
                    if (mul_done) begin
                        resp_result         <= mul_result;
                        resp_flags          <= {1'b0, mul_flags};
                        resp_tag            <= tag_q;
                        resp_valid[owner_q] <= 1'b1;
                        state_q             <= StResp;
                    end
`ifdef FP_MUL_SCHED_TIMEOUT_EN
                    else if (timeout_cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                        resp_result         <= CanonNan;
                        resp_flags          <= 5'b11000;
                        resp_tag            <= tag_q;
                        resp_valid[owner_q] <= 1'b1;
                        state_q             <= StResp;
                    end else begin
                        timeout_cnt_q <= timeout_cnt_q + 1'b1;
                    end
`endif
                end
                StResp: begin
                    if (resp_ready[owner_q]) begin
                        resp_valid <= '0;
                        state_q    <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (NUM_REQ >= 2 && NUM_REQ <= 8 && TIMEOUT_CYCLES >= 1)
                else $error("fp_mul_scheduler: parameter out of range");
        end
    end

endmodule

// File: tb/tb_fp_mul_scheduler.sv
// Directed bench for fp_mul_scheduler; the multiplier is modelled by hand-driven busy/done.
// Stimulus is applied on the falling edge and outputs are checked 1 time unit later.
module tb_fp_mul_scheduler;

    localparam int unsigned FLEN    = 32;
    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned TAG_W   = 5;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*FLEN-1:0]  req_operand_a;
    logic [NUM_REQ*FLEN-1:0]  req_operand_b;
    logic [NUM_REQ*3-1:0]     req_rm;
    logic [NUM_REQ*TAG_W-1:0] req_tag;
    logic [NUM_REQ-1:0]       resp_valid;
    logic [NUM_REQ-1:0]       resp_ready;
    logic [FLEN-1:0]          resp_result;
    logic [4:0]               resp_flags;
    logic [TAG_W-1:0]         resp_tag;
    logic                     mul_start;
    logic [2:0]               mul_rounding_mode;
    logic [FLEN-1:0]          mul_operand_a;
    logic [FLEN-1:0]          mul_operand_b;
    logic                     mul_busy;
    logic                     mul_done;
    logic [FLEN-1:0]          mul_result;
    logic [3:0]               mul_flags;

    int n_checks = 0;
    int n_fail   = 0;
    int start_cnt = 0;
    logic seen_rdy1 = 1'b0;

    fp_mul_scheduler #(
        .FLEN          (FLEN),
        .NUM_REQ       (NUM_REQ),
        .TAG_W         (TAG_W),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_operand_a    (req_operand_a),
        .req_operand_b    (req_operand_b),
        .req_rm           (req_rm),
        .req_tag          (req_tag),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_result      (resp_result),
        .resp_flags       (resp_flags),
        .resp_tag         (resp_tag),
        .mul_start        (mul_start),
        .mul_rounding_mode(mul_rounding_mode),
        .mul_operand_a    (mul_operand_a),
        .mul_operand_b    (mul_operand_b),
        .mul_busy         (mul_busy),
        .mul_done         (mul_done),
        .mul_result       (mul_result),
        .mul_flags        (mul_flags)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mul_start === 1'b1) start_cnt++;
        if (req_ready[1] === 1'b1) seen_rdy1 = 1'b1;
    end

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Multiplier stand-in: waits for start, stays busy, then pulses done with the given result.
    // Returns 1 time unit after the falling edge where resp_valid should be visible.
    task automatic serve_mul(input logic [31:0] res, input logic [3:0] fl,
                             input int unsigned busy_cyc);
        int unsigned w = 0;
        while (mul_start !== 1'b1 && w < 10) begin
            @(negedge clk);
            #1;
            w++;
        end
        n_checks++;
        if (mul_start !== 1'b1) begin
            n_fail++;
            $display("FAIL serve_mul_start: mul_start=%b, required 1 within 10 cycles", mul_start);
        end
        mul_busy = 1'b1;
        repeat (busy_cyc) @(negedge clk);
        mul_busy   = 1'b0;
        mul_done   = 1'b1;
        mul_result = res;
        mul_flags  = fl;
        @(negedge clk);
        mul_done   = 1'b0;
        mul_result = '0;
        mul_flags  = '0;
        #1;
    endtask

    task automatic handshake(input logic [1:0] who);
        resp_ready = who;
        @(negedge clk);
        resp_ready = '0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = '0; req_operand_a = '0; req_operand_b = '0; req_rm = '0; req_tag = '0;
        resp_ready = '0; mul_busy = 1'b0; mul_done = 1'b0; mul_result = '0; mul_flags = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if ({mul_start, resp_valid, req_ready} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: start/resp_valid/req_ready=%b, required 0",
                     {mul_start, resp_valid, req_ready});
        end
        n_checks++;
        if ({mul_operand_a, mul_operand_b, mul_rounding_mode, resp_result, resp_flags, resp_tag}
            !== '0) begin
            n_fail++;
            $display("FAIL reset_data: mul_a=%h resp_result=%h flags=%b tag=%0d, required 0",
                     mul_operand_a, resp_result, resp_flags, resp_tag);
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        pulse_reset();
        start_cnt = 0;
        seen_rdy1 = 1'b0;
        req_valid = 2'b01;
        req_operand_a[31:0] = 32'h3FC0_0000;
        req_operand_b[31:0] = 32'h4000_0000;
        req_rm[2:0] = 3'd0;
        req_tag[4:0] = 5'd3;
        #1;
        n_checks++;
        if (req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL single_ready: req_ready=%b, required 01", req_ready);
        end
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        n_checks++;
        if (mul_start !== 1'b1 || mul_operand_a !== 32'h3FC0_0000 || mul_operand_b !== 32'h4000_0000)
        begin
            n_fail++;
            $display("FAIL single_issue: start=%b a=%h b=%h, required 1 3fc00000 40000000",
                     mul_start, mul_operand_a, mul_operand_b);
        end
        serve_mul(32'h4040_0000, 4'b0000, 2);
        n_checks++;
        if (resp_valid !== 2'b01 || resp_result !== 32'h4040_0000 || resp_flags !== 5'b0 ||
            resp_tag !== 5'd3) begin
            n_fail++;
            $display("FAIL single_resp: valid=%b result=%h flags=%b tag=%0d, required 01 40400000 0 3",
                     resp_valid, resp_result, resp_flags, resp_tag);
        end
        handshake(2'b01);
        n_checks++;
        if (resp_valid !== 2'b00 || start_cnt != 1 || seen_rdy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_after: valid=%b starts=%0d rdy1_seen=%b, required 00 1 0",
                     resp_valid, start_cnt, seen_rdy1);
        end
    endtask

    task automatic test_contention();
        pulse_reset();
        req_valid = 2'b11;
        req_operand_a = {32'h4000_0000, 32'h3FC0_0000};
        req_operand_b = {32'h4040_0000, 32'h4000_0000};
        req_tag = {5'd2, 5'd1};
        #1;
        n_checks++;
        if (req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL cont_first: req_ready=%b, required 01", req_ready);
        end
        @(negedge clk);
        req_valid = 2'b10;
        #1;
        serve_mul(32'h4040_0000, 4'b0000, 1);
        n_checks++;
        if (resp_valid !== 2'b01 || resp_tag !== 5'd1) begin
            n_fail++;
            $display("FAIL cont_resp0: valid=%b tag=%0d, required 01 1", resp_valid, resp_tag);
        end
        handshake(2'b01);
        n_checks++;
        if (req_ready !== 2'b10) begin
            n_fail++;
            $display("FAIL cont_second: req_ready=%b, required 10", req_ready);
        end
        @(negedge clk);
        req_valid = 2'b11;
        #1;
        n_checks++;
        if (mul_operand_a !== 32'h4000_0000 || req_ready !== 2'b00) begin
            n_fail++;
            $display("FAIL cont_issue1: mul_a=%h req_ready=%b, required 40000000 00",
                     mul_operand_a, req_ready);
        end
        serve_mul(32'h40C0_0000, 4'b0000, 1);
        n_checks++;
        if (resp_valid !== 2'b10 || resp_result !== 32'h40C0_0000 || resp_tag !== 5'd2) begin
            n_fail++;
            $display("FAIL cont_resp1: valid=%b result=%h tag=%0d, required 10 40c00000 2",
                     resp_valid, resp_result, resp_tag);
        end
        handshake(2'b10);
        n_checks++;
        if (req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL cont_wrap: req_ready=%b, required 01", req_ready);
        end
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        serve_mul(32'h4040_0000, 4'b0000, 1);
        handshake(2'b01);
    endtask

    task automatic test_operand_hold();
        logic held = 1'b1;
        req_valid = 2'b10;
        req_operand_a[63:32] = 32'h4000_0000;
        req_operand_b[63:32] = 32'h4040_0000;
        req_rm[5:3] = 3'd3;
        req_tag[9:5] = 5'd7;
        #1;
        n_checks++;
        if (req_ready !== 2'b10) begin
            n_fail++;
            $display("FAIL hold_ready: req_ready=%b, required 10", req_ready);
        end
        @(negedge clk);
        req_valid = 2'b00;
        req_operand_a[63:32] = 32'hFFFF_FFFF;
        req_rm[5:3] = 3'd0;
        #1;
        mul_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (mul_operand_a !== 32'h4000_0000 || mul_rounding_mode !== 3'd3) held = 1'b0;
            @(negedge clk);
            #1;
        end
        mul_busy = 1'b0;
        mul_done = 1'b1;
        mul_result = 32'h40C0_0000;
        @(negedge clk);
        mul_done = 1'b0;
        #1;
        if (mul_operand_a !== 32'h4000_0000 || mul_rounding_mode !== 3'd3) held = 1'b0;
        n_checks++;
        if (held !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_operands: mul_a=%h rm=%0d, required 40000000 3",
                     mul_operand_a, mul_rounding_mode);
        end
        n_checks++;
        if (resp_valid !== 2'b10 || resp_result !== 32'h40C0_0000 || resp_tag !== 5'd7) begin
            n_fail++;
            $display("FAIL hold_resp: valid=%b result=%h tag=%0d, required 10 40c00000 7",
                     resp_valid, resp_result, resp_tag);
        end
        handshake(2'b10);
    endtask

    task automatic test_backpressure();
        logic stable = 1'b1;
        req_valid = 2'b01;
        req_tag[4:0] = 5'd9;
        @(negedge clk);
        req_valid = 2'b10;
        #1;
        serve_mul(32'h4040_0000, 4'b0001, 1);
        resp_ready = 2'b10;
        for (int i = 0; i < 10; i++) begin
            if (resp_valid !== 2'b01 || resp_result !== 32'h4040_0000 ||
                resp_flags !== 5'b00001 || resp_tag !== 5'd9 || req_ready !== 2'b00)
                stable = 1'b0;
            @(negedge clk);
            #1;
        end
        n_checks++;
        if (stable !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_stable: valid=%b result=%h flags=%b tag=%0d ready=%b, required 01 40400000 00001 9 00",
                     resp_valid, resp_result, resp_flags, resp_tag, req_ready);
        end
        handshake(2'b01);
        n_checks++;
        if (req_ready !== 2'b10) begin
            n_fail++;
            $display("FAIL bp_grant: req_ready=%b, required 10", req_ready);
        end
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        serve_mul(32'h40C0_0000, 4'b0000, 1);
        handshake(2'b10);
    endtask

    task automatic test_reset_drain();
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b00;
        mul_busy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req_valid = 2'b11;
        #1;
        n_checks++;
        if (req_ready !== 2'b00 || resp_valid !== 2'b00 || mul_operand_a !== 32'h0) begin
            n_fail++;
            $display("FAIL drain_busy: req_ready=%b resp_valid=%b mul_a=%h, required 00 00 0",
                     req_ready, resp_valid, mul_operand_a);
        end
        @(negedge clk);
        mul_busy = 1'b0;
        mul_done = 1'b1;
        mul_result = 32'hDEAD_BEEF;
        #1;
        n_checks++;
        if (req_ready !== 2'b00) begin
            n_fail++;
            $display("FAIL drain_done: req_ready=%b, required 00", req_ready);
        end
        @(negedge clk);
        mul_done = 1'b0;
        mul_result = '0;
        #1;
        n_checks++;
        if (resp_valid !== 2'b00 || req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL drain_after: resp_valid=%b req_ready=%b, required 00 01",
                     resp_valid, req_ready);
        end
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        serve_mul(32'h4040_0000, 4'b0000, 1);
        n_checks++;
        if (resp_valid !== 2'b01 || resp_result !== 32'h4040_0000) begin
            n_fail++;
            $display("FAIL drain_reissue: valid=%b result=%h, required 01 40400000",
                     resp_valid, resp_result);
        end
        handshake(2'b01);
    endtask

`ifdef FP_MUL_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int cycles = 0;
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        while (resp_valid === 2'b00 && cycles < 20) begin
            @(negedge clk);
            #1;
            cycles++;
        end
        n_checks++;
        if (cycles != 9 || resp_valid !== 2'b01 || resp_result !== 32'h7FC0_0000 ||
            resp_flags !== 5'b11000) begin
            n_fail++;
            $display("FAIL timeout_resp: cycles=%0d valid=%b result=%h flags=%b, required 9 01 7fc00000 11000",
                     cycles, resp_valid, resp_result, resp_flags);
        end
        handshake(2'b01);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_operand_hold();
        test_backpressure();
        test_reset_drain();
`ifdef FP_MUL_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/fp_mul_scheduler.md
Name: fp_mul_scheduler

Overview:
- Shares one FP multiplier instance (FMUL.S/D unit, start/busy/done handshake) between NUM_REQ issue requesters.
- Round-robin arbitration, one operation in flight at a time.
- Registers operands and rounding mode and holds them stable for the whole multiplier operation.
- Captures the multiplier's result and flags, then returns them to the owning requester with its tag.

Parameters:
- FLEN, 32, operand width (32 single, 64 double).
- NUM_REQ, 2, number of requesters (2..8).
- TAG_W, 5, width of the opaque per-request tag (e.g. destination register).
- TIMEOUT_CYCLES, 64, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  request pending, per requester.
- req_ready  out  NUM_REQ  request accepted this cycle, one-hot or zero.
- req_operand_a  in  NUM_REQ*FLEN  operand A; requester i at bits [i*FLEN +: FLEN].
- req_operand_b  in  NUM_REQ*FLEN  operand B, same packing.
- req_rm  in  NUM_REQ*3  rounding mode, packed [i*3 +: 3].
- req_tag  in  NUM_REQ*TAG_W  tag, packed [i*TAG_W +: TAG_W].
- resp_valid  out  NUM_REQ  response for requester i, one-hot or zero.
- resp_ready  in  NUM_REQ  requester i accepts the response.
- resp_result  out  FLEN  product.
- resp_flags  out  5  {timeout, nv, of, uf, nx}.
- resp_tag  out  TAG_W  tag of the completed request.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_rounding_mode  out  3  to the multiplier.
- mul_operand_a  out  FLEN  to the multiplier.
- mul_operand_b  out  FLEN  to the multiplier.
- mul_busy  in  1  from the multiplier.
- mul_done  in  1  from the multiplier; one-cycle pulse.
- mul_result  in  FLEN  from the multiplier; valid while mul_done=1.
- mul_flags  in  4  {nv, of, uf, nx} from the multiplier; valid while mul_done=1.

Behaviour:
- Reset (clk edge with reset=1):
  - state=IDLE, rr_ptr=0.
  - All outputs 0: mul_* registers, resp_* registers, req_ready, resp_valid.
- States:
  - IDLE: while mul_busy=1 or mul_done=1, no grant is given (drains a multiplier still active from before reset; its result is discarded). Otherwise grant = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod NUM_REQ. req_ready[grant]=1 combinationally, only in IDLE. On acceptance: latch the operands, rm, tag and owner id; rr_ptr <= (grant+1) mod NUM_REQ; go to ISSUE.
  - ISSUE: mul_start=1 for exactly this cycle; go to WAIT.
  - WAIT: on mul_done=1, capture mul_result, mul_flags and timeout=0; go to RESP.
  - RESP: resp_valid[owner]=1, and resp_result/flags/tag stay stable until resp_ready[owner]=1, then return to IDLE. resp_ready bits of non-owners are ignored.
- Operand hold rule: mul_operand_a/b and mul_rounding_mode stay constant from ISSUE until the cycle after mul_done. The multiplier samples operands one cycle after start and rm several cycles later.
- Latency: acceptance at cycle T gives mul_start at T+1. resp_valid rises the cycle after mul_done. Earliest next acceptance is the cycle after the resp handshake, so there is no back-to-back issue.
- mul_done outside WAIT is ignored. A new req_valid during ISSUE/WAIT/RESP gets req_ready=0; the request must stay asserted.
- Simultaneous requests are resolved by rr_ptr order. A requester that withdraws before acceptance is allowed.
- Reset mid-operation (any state) returns to IDLE and drops any pending response. The requester must reissue.
- Response storage is one entry, so no queueing is required.

Optional Feature:
- Macro: FP_MUL_SCHED_TIMEOUT_EN.
- Enabled:
  - A counter clears on ISSUE and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without mul_done, go to RESP with the canonical NaN (FLEN=32: 0x7FC00000; FLEN=64: 0x7FF8000000000000) and flags {timeout=1, nv=1, of=0, uf=0, nx=0}.
  - The next IDLE grant waits until mul_busy=0. A late mul_done is discarded by the IDLE drain rule.
- Disabled: no counter; WAIT lasts until mul_done; resp_flags[4] is constant 0.

Test Plan:
- Single request: req0 sends a=0x3FC00000, b=0x40000000, rm=0, tag=3 -> one mul_start pulse at T+1; resp_valid[0] with result 0x40400000, flags 0, resp_tag=3; req_ready[1] stays 0 throughout.
- Contention with rr_ptr=0: req0 and req1 both valid -> req0 is served first and req1 next. Then both valid again -> req0 is served (pointer wrapped). Order is 0,1,0.
- Operand stability: req1 changes req_operand_a after acceptance -> mul_operand_a and mul_rounding_mode are unchanged until after mul_done. Result for 2.0*3.0 (0x40000000, 0x40400000) = 0x40C00000.
- Response backpressure: resp_ready[0]=0 for 10 cycles while req1 is valid -> resp signals are held stable, req_ready stays 0, req1 is granted only after the handshake.
- Reset in WAIT with mul_busy still high: no grant until mul_busy=0 and mul_done=0, and the stale mul_done produces no resp_valid.
- With FP_MUL_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=8: mul_done is never asserted -> resp at WAIT+8 with result 0x7FC00000 and flags 5'b11000.
